// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts bytes over valid/ready, serialises them MSB-first and counts
// overlapping pattern matches. Define SEQ_SCAN_ABORT_EN to add the abort input.
module seq_scan_ctrl #(
    parameter int PAT_W = 5,
    parameter int LEN_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    input  logic [7:0]       nbytes,
    input  logic [7:0]       din,
    input  logic             din_valid,
`ifdef SEQ_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             din_ready,
    output logic             x_out,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [PAT_W-1:0] hist, hist_nxt, mask;
    logic [LEN_W-1:0] vcnt, vcnt_nxt, eff_len;
    logic [7:0]       sreg, remaining;
    logic [2:0]       bit_idx;
    logic             match, abort_req;

`ifdef SEQ_SCAN_ABORT_EN
    assign abort_req = abort && (state == FETCH || state == SHIFT);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (nbytes != 8'd0) ? FETCH : DONE;
            FETCH:   if (din_valid) state_nxt = SHIFT;
            SHIFT:   if (bit_idx == 3'd7) state_nxt = (remaining != 8'd0) ? FETCH : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_req) state_nxt = IDLE;
    end

    always_comb begin
        din_ready = (state == FETCH) && !abort_req;
        x_out     = (state == SHIFT) ? sreg[7] : 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // Match is evaluated on the history as it will be after this bit shifts in.
    always_comb begin
        eff_len  = (len_q > PAT_W_L) ? PAT_W_L : len_q;
        hist_nxt = {hist[PAT_W-2:0], x_out};
        vcnt_nxt = (vcnt == PAT_W_L) ? vcnt : vcnt + LEN_W'(1);
        for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(eff_len));
        match = (state == SHIFT) && (eff_len != '0) && (vcnt_nxt >= eff_len) &&
                (((hist_nxt ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q     <= '0;
            len_q     <= '0;
            hist      <= '0;
            vcnt      <= '0;
            sreg      <= '0;
            remaining <= '0;
            bit_idx   <= '0;
            hit       <= 1'b0;
            match_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            hit <= 1'b0;
            if (state == IDLE && cfg_we) begin
                pat_q <= cfg_pat;
                len_q <= cfg_len;
            end
            case (state)
                IDLE: if (start) begin
                    hist      <= '0;
                    vcnt      <= '0;
                    match_cnt <= '0;
                    remaining <= nbytes;
                end
                FETCH: if (din_valid && !abort_req) begin
                    sreg      <= din;
                    remaining <= remaining - 8'd1;
                    bit_idx   <= 3'd0;
                end
                SHIFT: if (!abort_req) begin
                    hist    <= hist_nxt;
                    vcnt    <= vcnt_nxt;
                    sreg    <= {sreg[6:0], 1'b0};
                    bit_idx <= bit_idx + 3'd1;
                    hit     <= match;
                    if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: a bit-stream model queues expected serial bits and hit pulses,
// a negedge monitor pops and compares; two instances cover CNT_W=8 and CNT_W=2.
`timescale 1ns/1ps
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0, start = 1'b0, din_valid = 1'b0;
    logic [4:0] cfg_pat = '0;
    logic [2:0] cfg_len = '0;
    logic [7:0] nbytes = '0, din = '0;

    logic       din_ready, x_out, hit, busy, done;
    logic [7:0] match_cnt;
    logic       din_ready2, x_out2, hit2, busy2, done2;
    logic [1:0] match_cnt2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit exp_x[$];
    bit exp_hit[$];
    bit prev_shift = 1'b0;

    seq_scan_ctrl #(.PAT_W(5), .LEN_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .start(start), .nbytes(nbytes), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x_out(x_out), .hit(hit), .match_cnt(match_cnt),
        .busy(busy), .done(done)
    );

    seq_scan_ctrl #(.PAT_W(5), .LEN_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .start(start), .nbytes(nbytes), .din(din), .din_valid(din_valid),
        .din_ready(din_ready2), .x_out(x_out2), .hit(hit2), .match_cnt(match_cnt2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: SHIFT is the only busy state with din_ready and done both low.
    always @(negedge clk) begin
        bit cur_shift;
        bit e;
        if (!reset) begin
            prev_shift = 1'b0;
        end else begin
            cur_shift = busy && !din_ready && !done;
            if (prev_shift) begin
                check("hit_queue", 32'(exp_hit.size() != 0), 32'd1);
                if (exp_hit.size() != 0) begin
                    e = exp_hit.pop_front();
                    check("hit", 32'(hit), 32'(e));
                    check("hit_c2", 32'(hit2), 32'(e));
                end
            end else begin
                check("hit_idle", 32'(hit), 32'd0);
            end
            if (cur_shift) begin
                check("x_queue", 32'(exp_x.size() != 0), 32'd1);
                if (exp_x.size() != 0) begin
                    e = exp_x.pop_front();
                    check("x_out", 32'(x_out), 32'(e));
                end
            end else begin
                check("x_idle", 32'(x_out), 32'd0);
            end
            prev_shift = cur_shift;
        end
    end

    // Reference: a hit at bit k when the last eff_len stream bits equal the pattern.
    task automatic push_expect(input logic [4:0] pat, input int len, input logic [7:0] bytes[$]);
        bit s[$];
        bit m;
        int el;
        el = (len > 5) ? 5 : len;
        foreach (bytes[k])
            for (int b = 7; b >= 0; b--) s.push_back(bytes[k][b]);
        for (int k = 0; k < s.size(); k++) begin
            m = 1'b0;
            if (el > 0 && k + 1 >= el) begin
                m = 1'b1;
                for (int j = 0; j < el; j++)
                    if (s[k - el + 1 + j] != pat[el - 1 - j]) m = 1'b0;
            end
            exp_x.push_back(s[k]);
            exp_hit.push_back(m);
        end
    endtask

    task automatic scan(input string tn, input logic [4:0] pat, input logic [2:0] len,
                        input logic [7:0] bytes[$], input int stall, input int exp_cnt);
        int nb;
        int t0;
        int w;
        nb = bytes.size();
        push_expect(pat, int'(len), bytes);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_pat = pat; cfg_len = len; start = 1'b1; nbytes = 8'(nb);
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0; cfg_pat = '0; cfg_len = '0;
        t0 = cyc;
        for (int k = 0; k < nb; k++) begin
            w = 0;
            while (!din_ready && w < 40) begin @(posedge clk); #1; w++; end
            check({tn, "_fetch_wait"}, 32'(w < 40), 32'd1);
            if (k > 0) begin
                repeat (stall) begin
                    check({tn, "_stall_ready"}, 32'(din_ready), 32'd1);
                    // Config writes and restarts while busy must be ignored.
                    cfg_we = 1'b1; start = 1'b1; cfg_pat = 5'b00000; cfg_len = 3'd1;
                    @(posedge clk); #1;
                    cfg_we = 1'b0; start = 1'b0; cfg_len = '0;
                end
            end
            din = bytes[k]; din_valid = 1'b1;
            @(posedge clk); #1;
            din_valid = 1'b0; din = '0;
        end
        w = 0;
        while (!done && w < 40) begin @(posedge clk); #1; w++; end
        check({tn, "_done_wait"}, 32'(w < 40), 32'd1);
        check({tn, "_cycles"}, 32'(cyc - t0), 32'((nb == 0) ? 0 : 9 * nb + stall * (nb - 1)));
        check({tn, "_ready_in_done"}, 32'(din_ready), 32'd0);
        check({tn, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tn, "_match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
        check({tn, "_match_cnt_c2"}, 32'(match_cnt2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
        @(posedge clk); #1;
        check({tn, "_done_pulse"}, 32'(done), 32'd0);
        check({tn, "_busy_after"}, 32'(busy), 32'd0);
        check({tn, "_cnt_held"}, 32'(match_cnt), 32'(exp_cnt));
        check({tn, "_queues_drained"}, 32'(exp_x.size() + exp_hit.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] bq[$];
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk); #2 reset = 1'b1;

        bq.delete(); bq.push_back(8'hA8);
        scan("t1", 5'b10100, 3'd5, bq, 0, 1);

        bq.delete(); bq.push_back(8'hAA); bq.push_back(8'hAA);
        scan("t2", 5'b00101, 3'd3, bq, 0, 7);
        scan("t3", 5'b00101, 3'd3, bq, 3, 7);

        bq.delete(); bq.push_back(8'hFF);
        scan("t4", 5'b00001, 3'd1, bq, 0, 8);

        bq.delete();
        scan("t5a", 5'b00101, 3'd3, bq, 0, 0);
        bq.push_back(8'hFF);
        scan("t5b", 5'b11111, 3'd0, bq, 0, 0);

        // Reset during the 4th SHIFT cycle of a scan.
        bq.delete(); bq.push_back(8'hA8);
        push_expect(5'b10100, 5, bq);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_pat = 5'b10100; cfg_len = 3'd5; start = 1'b1; nbytes = 8'd1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        din = 8'hA8; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        exp_x.delete(); exp_hit.delete();
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(din_ready), 32'd0);
        check("t6_x", 32'(x_out), 32'd0);
        check("t6_hit", 32'(hit), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk); #2 reset = 1'b1;
        bq.delete(); bq.push_back(8'h40);
        scan("t6b", 5'b00101, 3'd3, bq, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
